// File: rtl/reg_bus_pkg.sv
// Shared types and default sizing for the register-bus sequencer.
// REG_BUS_BCAST_EN (optional) adds broadcast writes; see reg_bus_seq.
package reg_bus_pkg;

  localparam int STATE_W        = 3;
  localparam int DEFAULT_WIDTH  = 16;
  localparam int DEFAULT_NREGS  = 8;
  localparam int DEFAULT_ADDR_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    RESP   = 3'd4
  } state_e;

endpackage

// File: rtl/reg_sel_dec.sv
// Address to active-low one-hot select decoder with range check.
// With REG_BUS_BCAST_EN defined, a broadcast write selects every register.
module reg_sel_dec
  import reg_bus_pkg::*;
#(
  parameter int NREGS  = DEFAULT_NREGS,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              en,
`ifdef REG_BUS_BCAST_EN
  input  logic              write,
  input  logic              bcast,
`endif
  input  logic [ADDR_W-1:0] addr,
  output logic [NREGS-1:0]  sel_n,
  output logic              err
);

  localparam logic [ADDR_W:0] NREGS_CMP = (ADDR_W+1)'(NREGS);

  logic bcast_wr;

  always_comb begin
    bcast_wr = 1'b0;
    err      = !({1'b0, addr} < NREGS_CMP);
`ifdef REG_BUS_BCAST_EN
    // A broadcast read has no single source on the shared read bus.
    if (bcast) begin
      bcast_wr = write;
      err      = !write;
    end
`endif
    sel_n = '1;
    for (int i = 0; i < NREGS; i++) begin
      if (en && !err && (bcast_wr || addr == ADDR_W'(i))) begin
        sel_n[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/reg_bus_seq.sv
// Request/response sequencer generating sel_n/we_n strobes for the register bank.
// Optional macro REG_BUS_BCAST_EN adds req_bcast for broadcast writes.
//
// state  | meaning
// IDLE   | req_ready=1, waiting for a request
// SETUP  | select asserted, write data on the bus
// STROBE | select held; we_n low for valid writes, read data sampled on exit
// HOLD   | all strobes released, bus turnaround
// RESP   | rsp_valid=1 until rsp_ready
module reg_bus_seq
  import reg_bus_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int NREGS  = DEFAULT_NREGS,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
`ifdef REG_BUS_BCAST_EN
  input  logic              req_bcast,
`endif
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WIDTH-1:0]  req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WIDTH-1:0]  rsp_rdata,
  output logic              rsp_err,
  output logic [NREGS-1:0]  sel_n,
  output logic              we_n,
  output logic [WIDTH-1:0]  wr_data,
  input  logic [WIDTH-1:0]  rd_data
);

  state_e              state_q, state_d;
  logic                req_ready_q;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WIDTH-1:0]    wr_data_q, wr_data_d;
  logic [NREGS-1:0]    sel_n_q;
  logic                we_n_q;
  logic                rsp_valid_q;
  logic [WIDTH-1:0]    rsp_rdata_q;
  logic                rsp_err_q;
  logic                accept;
  logic                sel_en;
  logic [NREGS-1:0]    dec_sel_n;
  logic                dec_err;
`ifdef REG_BUS_BCAST_EN
  logic                bcast_q, bcast_d;
`endif

  always_comb begin
    state_d   = state_q;
    accept    = req_valid && req_ready_q && (state_q == IDLE);
    write_d   = write_q;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
`ifdef REG_BUS_BCAST_EN
    bcast_d   = bcast_q;
`endif
    if (accept) begin
      write_d   = req_write;
      addr_d    = req_addr;
      wr_data_d = req_wdata;
`ifdef REG_BUS_BCAST_EN
      bcast_d   = req_bcast;
`endif
    end
    case (state_q)
      IDLE:    if (accept) state_d = SETUP;
      SETUP:   state_d = STROBE;
      STROBE:  state_d = HOLD;
      HOLD:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Decode against next-state values so every strobe output can be registered.
  assign sel_en = (state_d == SETUP) || (state_d == STROBE);

  reg_sel_dec #(
    .NREGS  (NREGS),
    .ADDR_W (ADDR_W)
  ) u_dec (
    .en    (sel_en),
`ifdef REG_BUS_BCAST_EN
    .write (write_d),
    .bcast (bcast_d),
`endif
    .addr  (addr_d),
    .sel_n (dec_sel_n),
    .err   (dec_err)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wr_data_q   <= '0;
      sel_n_q     <= '1;
      we_n_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= (state_d == IDLE);
      write_q     <= write_d;
      addr_q      <= addr_d;
      wr_data_q   <= wr_data_d;
      sel_n_q     <= dec_sel_n;
      we_n_q      <= !((state_d == STROBE) && write_d && !dec_err);
      rsp_valid_q <= (state_d == RESP);
      if (state_q == STROBE) begin
        rsp_err_q   <= dec_err;
        rsp_rdata_q <= (!write_q && !dec_err) ? rd_data : '0;
      end
    end
  end

`ifdef REG_BUS_BCAST_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) bcast_q <= 1'b0;
    else       bcast_q <= bcast_d;
  end
`endif

  assign req_ready = req_ready_q;
  assign sel_n     = sel_n_q;
  assign we_n      = we_n_q;
  assign wr_data   = wr_data_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_reg_bus_seq.sv
// Scoreboard bench for reg_bus_seq with a behavioural register bank on the strobe bus.
module tb_reg_bus_seq;
  localparam int W  = 16;
  localparam int NR = 6;
  localparam int AW = 3;

  typedef struct packed {
    logic [W-1:0] rdata;
    logic         err;
  } rsp_t;

  logic          clk = 1'b0;
  logic          rstn;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [W-1:0]  req_wdata;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [W-1:0]  rsp_rdata;
  logic          rsp_err;
  logic [NR-1:0] sel_n;
  logic          we_n;
  logic [W-1:0]  wr_data;
  logic [W-1:0]  rd_data;
`ifdef REG_BUS_BCAST_EN
  logic          req_bcast;
`endif

  int   total = 0;
  int   bad = 0;
  int   rdy_mode = 0;
  rsp_t exp_q[$];
  logic [W-1:0] mem  [NR];
  logic [W-1:0] bank [NR] = '{default: '0};

  always #5 clk = ~clk;

  reg_bus_seq #(.WIDTH(W), .NREGS(NR), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
`ifdef REG_BUS_BCAST_EN
    .req_bcast (req_bcast),
`endif
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .sel_n     (sel_n),
    .we_n      (we_n),
    .wr_data   (wr_data),
    .rd_data   (rd_data)
  );

  // Register cells: capture on sel_n & we_n low, drive the shared read bus when selected.
  always @(posedge clk) begin
    for (int i = 0; i < NR; i++)
      if (!sel_n[i] && !we_n) bank[i] <= wr_data;
  end

  always_comb begin
    rd_data = 16'hBEEF;
    for (int i = 0; i < NR; i++)
      if (!sel_n[i] && we_n) rd_data = bank[i];
  end

  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       rsp_ready = 1'b1;
      1:       rsp_ready = 1'($urandom_range(0, 1));
      default: rsp_ready = 1'b0;
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Response monitor: compares every presented response, pops on handshake.
  always @(negedge clk) begin
    if (rstn === 1'b1 && rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp_unexpected: got rdata=%h err=%b, expected no response", rsp_rdata, rsp_err);
      end else begin
        chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_q[0].rdata));
        chk("rsp_err", 32'(rsp_err), 32'(exp_q[0].err));
        if (rsp_ready) void'(exp_q.pop_front());
      end
    end
  end

`ifndef REG_BUS_BCAST_EN
  always @(negedge clk) begin
    if (rstn === 1'b1) chk("sel_onehot", 32'($countones(~sel_n) <= 1), 32'd1);
  end
`endif

  task automatic do_req(input logic wr, input logic [AW-1:0] a, input logic [W-1:0] d,
                        input logic bc);
    logic          err;
    logic [NR-1:0] esel;
    rsp_t          e;
    int            n;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
`ifdef REG_BUS_BCAST_EN
    req_bcast = bc;
`endif
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      chk("req_ready_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    err  = bc ? !wr : (int'(a) >= NR);
    esel = '1;
    if (!err) begin
      if (bc) esel = '0;
      else    esel[a] = 1'b0;
    end
    e.err   = err;
    e.rdata = (!wr && !err) ? mem[a] : '0;
    exp_q.push_back(e);
    if (wr && !err) begin
      if (bc) for (int i = 0; i < NR; i++) mem[i] = d;
      else    mem[a] = d;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = AW'($urandom);
    req_wdata = W'($urandom);
    chk("setup_sel_n", 32'(sel_n), 32'(esel));
    chk("setup_we_n", 32'(we_n), 32'd1);
    chk("setup_wr_data", 32'(wr_data), 32'(d));
    chk("setup_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("strobe_sel_n", 32'(sel_n), 32'(esel));
    chk("strobe_we_n", 32'(we_n), 32'(!(wr && !err)));
    chk("strobe_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("hold_sel_n", 32'(sel_n), 32'(6'h3F));
    chk("hold_we_n", 32'(we_n), 32'd1);
    chk("hold_wr_data", 32'(wr_data), 32'(d));
    chk("hold_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("resp_latency", 32'(rsp_valid), 32'd1);
  endtask

  task automatic drain();
    int n;
    rdy_mode = 0;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic bc;
    rstn      = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
`ifdef REG_BUS_BCAST_EN
    req_bcast = 1'b0;
`endif
    for (int i = 0; i < NR; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_sel_n", 32'(sel_n), 32'(6'h3F));
    chk("rst_we_n", 32'(we_n), 32'd1);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    rstn = 1'b1;
    @(posedge clk);
    #1 chk("rel_req_ready", 32'(req_ready), 32'd1);

    // Reset in the middle of SETUP of a write to register 2: dropped, nothing written.
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 3'd2;
    req_wdata = 16'h1234;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("mid_setup_sel_n", 32'(sel_n), 32'(6'b111011));
    rstn = 1'b0;
    #1;
    chk("async_rst_sel_n", 32'(sel_n), 32'(6'h3F));
    chk("async_rst_we_n", 32'(we_n), 32'd1);
    chk("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    #1 chk("post_rst_req_ready_low", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1 chk("post_rst_req_ready", 32'(req_ready), 32'd1);

    do_req(1'b1, 3'd3, 16'hAAAA, 1'b0);
    do_req(1'b0, 3'd3, 16'h0000, 1'b0);
    do_req(1'b0, 3'd5, 16'h0000, 1'b0);
    do_req(1'b0, 3'd2, 16'h0000, 1'b0);
    do_req(1'b0, 3'd7, 16'h0000, 1'b0);
    do_req(1'b1, 3'd6, 16'hFFFF, 1'b0);

    // Backpressure: response must be held while rsp_ready stays low.
    rdy_mode = 2;
    do_req(1'b0, 3'd3, 16'h0000, 1'b0);
    repeat (10) begin
      @(negedge clk);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    rdy_mode = 0;
    n = 0;
    while (rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_exit_req_ready", 32'(req_ready), 32'd1);

    rdy_mode = 1;
    repeat (40) begin
      bc = 1'b0;
`ifdef REG_BUS_BCAST_EN
      bc = ($urandom_range(0, 4) == 0);
`endif
      do_req(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), W'($urandom), bc);
    end
    drain();

`ifdef REG_BUS_BCAST_EN
    do_req(1'b1, 3'd7, 16'h5A5A, 1'b1);
    do_req(1'b0, 3'd1, 16'h0000, 1'b1);
`endif
    for (int i = 0; i < NR; i++) do_req(1'b0, AW'(i), 16'h0000, 1'b0);
    drain();
    for (int i = 0; i < NR; i++) chk("bank_contents", 32'(bank[i]), 32'(mem[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
